contador_programa: RTL and testbench
====================================

Name: contador_programa

Overview:
Program-counter stage feeding the instruction fetch memory (word-addressed, `instrucao = Memoria[pc]` registered on posedge clk).
- Generates the next word address: sequential increment, beq-relative branch, or J-type jump.
- Supports stall, a bounded program size with halt/restart, and a flush pulse so downstream discards the wrong-path instruction fetched after a taken branch or jump.

Parameters:
PROG_WORDS, 11, number of valid instruction words; valid addresses are 0..PROG_WORDS-1.
RESET_PC, 0, word address loaded on reset and on restart.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
stall  input  1  hold pc this cycle (hazard from downstream).
desvio  input  1  beq resolved taken this cycle.
imediato  input  16  beq word offset, signed two's complement.
salto  input  1  J-type jump this cycle.
endereco_salto  input  26  jump word index.
reiniciar  input  1  leave HALT and restart at RESET_PC.
pc  output  32  current fetch word address (drives fetch memory pc).
pc_mais1  output  32  pc+1, combinational from pc.
flush  output  1  one-cycle pulse: instruction arriving next from fetch is wrong-path.
halted  output  1  state is HALT.
erro_endereco  output  1  sticky: a branch or jump target was out of range.
contador_instr  output  16  number of pc advances since reset/restart.

Behaviour:
Reset (rst_n=0, asynchronous):
- pc=RESET_PC, state=RUN.
- flush=0, halted=0, erro_endereco=0, contador_instr=0.

States:
- RUN: normal fetch.
- HALT: pc frozen; all inputs except reiniciar ignored.

Next-pc selection in RUN, by priority:
1. stall=1: pc holds, contador_instr holds, flush=0. desvio and salto are ignored, so the requester must hold them until stall drops.
2. salto=1: alvo = {pc_mais1[31:26], endereco_salto}.
3. desvio=1: alvo = pc_mais1 + sign_extend32(imediato).
4. Otherwise: alvo = pc_mais1.

All address arithmetic is 32-bit modulo 2^32. salto wins over a simultaneous desvio.

Range check: if alvo < PROG_WORDS:
- pc <= alvo, contador_instr <= contador_instr+1 (wraps at 16 bits).
- flush <= 1 if case 2 or 3 was taken, else 0.

Out of range: if alvo >= PROG_WORDS (unsigned):
- pc holds, state -> HALT, halted=1 from the next cycle, flush=0, contador_instr holds.
- erro_endereco <= 1 only if the target came from case 2 or 3. A sequential run-off is a normal end of program.

HALT:
- reiniciar=1: pc <= RESET_PC, state -> RUN, halted <= 0, contador_instr <= 0. erro_endereco is kept; only rst_n clears it.
- reiniciar=1 while in RUN has no effect.

Timing:
- pc changes one cycle after the decision.
- Fetch output is one further cycle behind pc, so flush is registered and aligned to the cycle in which fetch presents the instruction at the old pc_mais1.
- flush is never high for two consecutive cycles unless two consecutive taken transfers occur.

Boundaries:
- Branch to pc itself (imediato=0xFFFF) is legal.
- Negative targets wrap to large unsigned values and therefore halt with erro_endereco=1.
- rst_n asserted in any state, including mid-stall or in HALT, forces the reset values immediately.
- rst_n deassertion is synchronized externally; no behaviour is defined for it within a setup window.

Outputs are registered except pc_mais1.

Test Plan:
Sequential run-off:
- Stimulus: reset release, no inputs, PROG_WORDS=11.
- Response: pc steps 0,1,...,10; on the next cycle halted=1, pc stays 10, contador_instr=10, erro_endereco=0, flush never asserted.

Taken branch backward:
- Stimulus: at pc=2, desvio=1, imediato=0xFFFE.
- Response: next pc=1, flush=1 for exactly one cycle, contador_instr +1.

Jump, and jump beating branch:
- Stimulus: at pc=3, salto=1, endereco_salto=7, desvio=1, imediato=0x0001.
- Response: pc=7 (jump wins), flush=1.

Stall blocks branch:
- Stimulus: at pc=4, stall=1 with desvio=1, imediato=0x0002 for 3 cycles, then stall=0 with desvio held.
- Response: pc holds 4 for 3 cycles with contador_instr unchanged, then pc=7 and flush=1.

Out-of-range branch, then restart:
- Stimulus: at pc=5, desvio=1, imediato=0x000A (target 16).
- Response: pc stays 5, halted=1, erro_endereco=1, all inputs ignored.
- Stimulus: reiniciar=1.
- Response: pc=0, halted=0, contador_instr=0, erro_endereco still 1.

Reset mid-operation:
- Stimulus: rst_n low asynchronously at pc=6 between clock edges.
- Response: pc=0 and all outputs at reset values before the next edge; they remain there while rst_n=0.

Source files
------------

// File: rtl/contador_programa.sv
// Program counter for the word-addressed fetch memory:
// sequential, branch and jump targets, bounded program with halt/restart.
module contador_programa #(
    parameter int          PROG_WORDS = 11,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        desvio,
    input  logic [15:0] imediato,
    input  logic        salto,
    input  logic [25:0] endereco_salto,
    input  logic        reiniciar,
    output logic [31:0] pc,
    output logic [31:0] pc_mais1,
    output logic        flush,
    output logic        halted,
    output logic        erro_endereco,
    output logic [15:0] contador_instr
);

    typedef enum logic {RUN, HALT} estado_t;

    localparam logic [31:0] LIMITE = 32'(PROG_WORDS);

    estado_t     estado;
    logic [31:0] alvo;
    logic        transfere;

    assign pc_mais1 = pc + 32'd1;

    // salto beats desvio; transfere marks a non-sequential target
    always_comb begin
        alvo      = pc_mais1;
        transfere = 1'b0;
        if (salto) begin
            alvo      = {pc_mais1[31:26], endereco_salto};
            transfere = 1'b1;
        end else if (desvio) begin
            alvo      = pc_mais1 + {{16{imediato[15]}}, imediato};
            transfere = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= RUN;
            pc             <= RESET_PC;
            flush          <= 1'b0;
            halted         <= 1'b0;
            erro_endereco  <= 1'b0;
            contador_instr <= 16'd0;
        end else begin
            flush <= 1'b0;
            case (estado)
                RUN: begin
                    if (!stall) begin
                        if (alvo < LIMITE) begin
                            pc             <= alvo;
                            contador_instr <= contador_instr + 16'd1;
                            flush          <= transfere;
                        end else begin
                            estado <= HALT;
                            halted <= 1'b1;
                            if (transfere)
                                erro_endereco <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (reiniciar) begin
                        estado         <= RUN;
                        pc             <= RESET_PC;
                        halted         <= 1'b0;
                        contador_instr <= 16'd0;
                    end
                end
                default: estado <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_contador_programa.sv
// Randomized scoreboard bench for contador_programa.
module tb_contador_programa;

    localparam int W = 11;

    logic        clk = 1'b1;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        desvio = 1'b0;
    logic [15:0] imediato = 16'd0;
    logic        salto = 1'b0;
    logic [25:0] endereco_salto = 26'd0;
    logic        reiniciar = 1'b0;
    logic [31:0] pc, pc_mais1;
    logic        flush, halted, erro_endereco;
    logic [15:0] contador_instr;

    contador_programa #(.PROG_WORDS(W), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .desvio(desvio),
        .imediato(imediato), .salto(salto),
        .endereco_salto(endereco_salto), .reiniciar(reiniciar),
        .pc(pc), .pc_mais1(pc_mais1), .flush(flush), .halted(halted),
        .erro_endereco(erro_endereco), .contador_instr(contador_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint pc;
        bit     flush;
        bit     halted;
        bit     err;
        int     cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // reference state
    longint m_pc = 0;
    bit     m_halt = 0, m_err = 0, m_flush = 0;
    int     m_cnt = 0;

    task automatic chk(string nm, longint act, longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, req, $time);
        end
    endtask

    function automatic void model(bit r, bit st, bit de, bit [15:0] im,
                                  bit sa, bit [25:0] js, bit re);
        longint p1, t;
        bit tk;
        m_flush = 0;
        if (!r) begin
            m_pc = 0; m_halt = 0; m_err = 0; m_cnt = 0;
        end else if (m_halt) begin
            if (re) begin
                m_pc = 0; m_halt = 0; m_cnt = 0;
            end
        end else if (!st) begin
            p1 = (m_pc + 1) % 64'h1_0000_0000;
            tk = sa | de;
            if (sa)
                t = (p1 / 64'h400_0000) * 64'h400_0000 + longint'(js);
            else if (de)
                t = (p1 + longint'($signed(im)) + 64'h1_0000_0000)
                    % 64'h1_0000_0000;
            else
                t = p1;
            if (t < W) begin
                m_pc = t;
                m_cnt = (m_cnt + 1) % 65536;
                m_flush = tk;
            end else begin
                m_halt = 1;
                if (tk) m_err = 1;
            end
        end
    endfunction

    task automatic drive(bit r, bit st, bit de, bit [15:0] im,
                         bit sa, bit [25:0] js, bit re);
        exp_t e;
        @(negedge clk);
        rst_n = r; stall = st; desvio = de; imediato = im;
        salto = sa; endereco_salto = js; reiniciar = re;
        model(r, st, de, im, sa, js, re);
        e.pc = m_pc; e.flush = m_flush; e.halted = m_halt;
        e.err = m_err; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 16'h0, 0, 26'h0, 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_pc", longint'(pc), 0);
        chk("async_flush", longint'(flush), 0);
        chk("async_halted", longint'(halted), 0);
        chk("async_err", longint'(erro_endereco), 0);
        chk("async_cnt", longint'(contador_instr), 0);
        drive(0, 0, 0, 16'h0, 0, 26'h0, 0);
        drive(0, 1, 1, 16'h1, 1, 26'h3, 1);
    endtask

    // monitor: every cycle the DUT presents a fetch address
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", longint'(pc), e.pc);
                chk("pc_mais1", longint'(pc_mais1),
                    (e.pc + 1) % 64'h1_0000_0000);
                chk("flush", longint'(flush), longint'(e.flush));
                chk("halted", longint'(halted), longint'(e.halted));
                chk("erro", longint'(erro_endereco), longint'(e.err));
                chk("contador", longint'(contador_instr), longint'(e.cnt));
            end
        end
    end

    initial begin
        bit st, de, sa, re;
        int imv;
        drive(0, 0, 0, 16'h0, 0, 26'h0, 0);
        drive(0, 0, 0, 16'h0, 0, 26'h0, 0);
        // sequential run-off to halt, then extra idle in HALT
        idle(14);
        drive(1, 0, 1, 16'h0001, 1, 26'h2, 0);
        drive(1, 0, 0, 16'h0, 0, 26'h0, 1);
        // backward branch at pc=2
        idle(2);
        drive(1, 0, 1, 16'hFFFE, 0, 26'h0, 0);
        // jump beats branch at pc=3
        idle(2);
        drive(1, 0, 1, 16'h0001, 1, 26'h7, 0);
        // stall holds a pending branch at pc=4
        drive(1, 0, 0, 16'h0, 1, 26'h4, 0);
        for (int i = 0; i < 3; i++)
            drive(1, 1, 1, 16'h0002, 0, 26'h0, 0);
        drive(1, 0, 1, 16'h0002, 0, 26'h0, 0);
        // branch to self, then out-of-range branch at pc=5
        drive(1, 0, 1, 16'hFFFF, 0, 26'h0, 0);
        drive(1, 0, 0, 16'h0, 1, 26'h5, 0);
        drive(1, 0, 1, 16'h000A, 0, 26'h0, 0);
        drive(1, 0, 1, 16'hFFF0, 1, 26'h1, 0);
        drive(1, 1, 0, 16'h0, 0, 26'h0, 1);
        // negative target wraps and halts
        drive(1, 0, 1, 16'hFFF0, 0, 26'h0, 0);
        drive(1, 0, 0, 16'h0, 0, 26'h0, 0);
        drive(1, 0, 0, 16'h0, 0, 26'h0, 1);
        idle(6);
        async_reset();
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom % 4) == 0;
            de = ($urandom % 4) == 0;
            sa = ($urandom % 7) == 0;
            re = ($urandom % 3) == 0;
            imv = int'($urandom_range(0, 14)) - 7;
            drive(1, st, de, 16'(imv), sa,
                  26'($urandom_range(0, 13)), re);
            if (n % 700 == 699) async_reset();
        end
        @(posedge clk);
        #3;
        chk("queue_drained", longint'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
